// File: rtl/fp32_result_drain.sv
// Result drain for one DSPFP32 PE: re-times FPA_OUT and its status flags to the
// issue strobe, buffers them in a FWFT FIFO and throttles issue with credits so
// no result is lost under any amount of consumer backpressure.
module fp32_result_drain #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [31:0]             fpa_out,
    input  logic                    fpa_invalid,
    input  logic                    fpa_overflow,
    input  logic                    fpa_underflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_data,
    output logic [2:0]              res_flags,
    output logic [2:0]              sticky_flags,
    input  logic                    sticky_clr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Wide enough to hold count + inflight without wrapping.
    localparam int unsigned SW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         sticky_q, sticky_d;
    logic [34:0]        mem_q [DEPTH];
    logic [SW-1:0]      inflight;
    logic               accept, push, pop;

    // Credits: every result already buffered or still inside the DSP owns a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SW'(vld_sr_q[i]);
        end
        issue_ready = (SW'(count_q) + inflight) < SW'(DEPTH);
    end

    assign accept       = issue_valid & issue_ready;
    assign push         = vld_sr_q[LATENCY-1];
    assign res_valid    = (count_q != '0);
    assign pop          = res_valid & res_ready;
    assign res_data     = mem_q[rd_ptr_q][34:3];
    assign res_flags    = mem_q[rd_ptr_q][2:0];
    assign sticky_flags = sticky_q;
    assign count        = count_q;

    // Next state: valid delay line, occupancy and sticky flag accumulation.
    always_comb begin
        vld_sr_d = '0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
        vld_sr_d[0] = accept;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A flag pushed on the clearing edge survives the clear.
        sticky_d = (sticky_clr ? 3'b000 : sticky_q)
                 | (push ? {fpa_invalid, fpa_overflow, fpa_underflow} : 3'b000);
    end

    // State registers; a push can never find the FIFO full thanks to the credits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_sr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_sr_q <= vld_sr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {fpa_out, fpa_invalid, fpa_overflow, fpa_underflow};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp32_result_drain.sv
// Directed bench for fp32_result_drain, plus a short random run on a
// DEPTH=2 / LATENCY=1 instance checked against a queue scoreboard.
module tb_fp32_result_drain;

    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 8;
    localparam logic [34:0] JUNK = {32'hDEADBEEF, 3'b111};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST;
    logic        issue_valid, issue_ready;
    logic [31:0] fpa_out;
    logic        fpa_invalid, fpa_overflow, fpa_underflow;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_flags, sticky_flags;
    logic        sticky_clr;
    logic [3:0]  count;

    logic        iv2, ir2, fi2, fov2, fu2, rv2, rr2;
    logic [31:0] fo2, rd2;
    logic [2:0]  rf2, st2;
    logic [1:0]  cnt2;

    fp32_result_drain #(.LATENCY(LAT), .DEPTH(DEP)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .fpa_out(fpa_out), .fpa_invalid(fpa_invalid),
        .fpa_overflow(fpa_overflow), .fpa_underflow(fpa_underflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count)
    );

    fp32_result_drain #(.LATENCY(1), .DEPTH(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(iv2), .issue_ready(ir2),
        .fpa_out(fo2), .fpa_invalid(fi2),
        .fpa_overflow(fov2), .fpa_underflow(fu2),
        .res_valid(rv2), .res_ready(rr2),
        .res_data(rd2), .res_flags(rf2),
        .sticky_flags(st2), .sticky_clr(1'b0), .count(cnt2)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_acc, n_pop, p0;
    logic [31:0] nd;
    logic [2:0]  nf;
    logic [34:0] exp_q [$];
    logic [34:0] pipe_e [LAT];
    logic        pipe_v [LAT];

    logic [34:0] q2 [$];
    logic [34:0] e2;
    logic [31:0] nd2;
    logic        pv2, is2;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the main DUT: state checks, scoreboard update, PE model shift.
    task automatic cycle(input logic iv, input logic rr, input logic clr);
        int          infl;
        logic        iss;
        logic [34:0] e;
        issue_valid = iv;
        res_ready   = rr;
        sticky_clr  = clr;
        #1;
        infl = 0;
        for (int k = 0; k < LAT; k++) infl += int'(pipe_v[k]);
        check("count", count, exp_q.size() - infl);
        check("issue_ready", issue_ready, exp_q.size() < DEP);
        check("res_valid", res_valid, (exp_q.size() - infl) != 0);
        if (res_valid && exp_q.size() > 0) check("head", {res_data, res_flags}, exp_q[0]);
        iss = issue_valid & issue_ready;
        e   = JUNK;
        if (iss) begin
            e = {nd, nf};
            exp_q.push_back(e);
            n_acc++;
            nd = nd + 32'h0102_0305;
            nf = 3'b000;
        end
        if (res_valid && res_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_pop++;
        end
        @(posedge CLK);
        #1;
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_e[k] = pipe_e[k-1];
            pipe_v[k] = pipe_v[k-1];
        end
        pipe_e[0] = e;
        pipe_v[0] = iss;
        {fpa_out, fpa_invalid, fpa_overflow, fpa_underflow} = pipe_e[LAT-1];
        @(negedge CLK);
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int k = 0; k < LAT; k++) begin
            pipe_e[k] = JUNK;
            pipe_v[k] = 1'b0;
        end
        {fpa_out, fpa_invalid, fpa_overflow, fpa_underflow} = JUNK;
    endtask

    initial begin
        nRST = 1'b0;
        issue_valid = 1'b0; res_ready = 1'b0; sticky_clr = 1'b0;
        iv2 = 1'b0; rr2 = 1'b0;
        {fo2, fi2, fov2, fu2} = JUNK;
        clear_model();
        n_acc = 0; n_pop = 0;
        nd = 32'h1234_5678; nf = 3'b000;
        nd2 = 32'h0A0B_0000; pv2 = 1'b0; is2 = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_sticky", sticky_flags, 3'b000);
        check("rst_res_data", {res_data, res_flags}, 35'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // 1: single issue, latency to res_valid
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        nd = 32'h3F80_0000;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("t1_not_yet", res_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t1_valid", res_valid, 1'b1);
        check("t1_data", res_data, 32'h3F80_0000);
        check("t1_flags", res_flags, 3'b000);
        check("t1_count", count, 4'd1);
        cycle(1'b0, 1'b1, 1'b0);
        check("t1_count_after_pop", count, 4'd0);

        // 2: full backpressure
        n_acc = 0;
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        check("t2_accepted", n_acc, 8);
        check("t2_count", count, 4'd8);
        check("t2_issue_ready", issue_ready, 1'b0);

        // 3: streaming with wrap, then drain
        n_pop = 0;
        for (int i = 0; i < 200 && n_pop < 100; i++) cycle(1'b1, 1'b1, 1'b0);
        check("t3_pops", n_pop >= 100, 1'b1);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        check("t3_drained", exp_q.size(), 0);
        check("t3_count", count, 4'd0);

        // 4: sticky clear coinciding with an overflow push
        cycle(1'b0, 1'b1, 1'b1);
        check("t4_sticky_clr", sticky_flags, 3'b000);
        nf = 3'b001;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        nf = 3'b010;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check("t4_sticky_before", sticky_flags, 3'b001);
        cycle(1'b0, 1'b1, 1'b1);
        check("t4_sticky_clr_push", sticky_flags, 3'b010);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check("t4_sticky_hold", sticky_flags, 3'b010);

        // 5: reset with 5 buffered and 3 in flight
        repeat (9) cycle(1'b1, 1'b0, 1'b0);
        check("t5_count_pre", count, 4'd5);
        #2;
        nRST = 1'b0;
        #1;
        check("t5_res_valid", res_valid, 1'b0);
        check("t5_count", count, 4'd0);
        check("t5_issue_ready", issue_ready, 1'b1);
        check("t5_sticky", sticky_flags, 3'b000);
        clear_model();
        @(posedge CLK);
        #1;
        check("t5_hold_valid", res_valid, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        p0 = n_pop;
        nd = 32'h7F80_0001;
        nf = 3'b100;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        check("t5_nan_popped", n_pop - p0, 1);
        check("t5_empty", exp_q.size(), 0);

        // 6: DEPTH=2, LATENCY=1 random valid/ready against a scoreboard
        for (int i = 0; i < 3000; i++) begin
            iv2 = 1'($urandom_range(0, 1));
            rr2 = 1'($urandom_range(0, 1));
            #1;
            check("t6_count", cnt2, q2.size() - int'(pv2));
            check("t6_ready", ir2, q2.size() < 2);
            if (rv2) begin
                if (q2.size() > 0) check("t6_head", {rd2, rf2}, q2[0]);
                else check("t6_spurious", rv2, 1'b0);
            end
            is2 = iv2 & ir2;
            e2  = JUNK;
            if (is2) begin
                e2 = {nd2, nd2[2:0]};
                q2.push_back(e2);
                nd2 = nd2 + 32'h0001_0003;
            end
            if (rv2 && rr2 && q2.size() > 0) void'(q2.pop_front());
            @(posedge CLK);
            #1;
            pv2 = is2;
            {fo2, fi2, fov2, fu2} = e2;
            @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
